ex_mem_reg: RTL and testbench

- EX/MEM pipeline register of the five-stage MIPS core. It sits directly downstream of the EX-stage ALU.
- Each cycle it captures the ALU result and the E-stage control/data fields, then presents them to the MEM stage.
- It ages the hazard counter Tnew by one stage.
- It drives the M-stage forwarding bus (address, data, ready) back to the D and E operand muxes.

---
 rtl/ex_mem_reg_pkg.sv | 17 +
 rtl/ex_mem_reg_m_fwd_sel.sv | 40 ++++
 rtl/ex_mem_reg.sv | 137 +++++++++++++
 tb/tb_ex_mem_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ex_mem_reg_pkg.sv
// Constants shared by the pipeline registers and the hazard unit of the
// five-stage MIPS core.
package ex_mem_reg_pkg;

   localparam logic [1:0]  WD_ALU   = 2'd0;
   localparam logic [1:0]  WD_MEM   = 2'd1;
   localparam logic [1:0]  WD_PC8   = 2'd2;

   localparam int          TNEW_W   = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   // Link value written by jal; wraps modulo 2^32.
   function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
      return pc + 32'd8;
   endfunction

endpackage

// File: rtl/ex_mem_reg_m_fwd_sel.sv
// M-stage forwarding select: derives the forwarded value and its validity
// from the registered EX/MEM state only.
module ex_mem_reg_m_fwd_sel #(
   parameter int TNEW_W = ex_mem_reg_pkg::TNEW_W
) (
   input  logic [1:0]        wd_sel,
   input  logic [4:0]        wa,
   input  logic [TNEW_W-1:0] tnew,
   input  logic              valid,
   input  logic [31:0]       alu_out,
   input  logic [31:0]       pc,
   output logic [31:0]       fwd_data,
   output logic              fwd_ok
);
   import ex_mem_reg_pkg::*;

   logic can_fwd_s;

   // Loads and the reserved encoding never forward from M; $0 is never forwarded.
   always_comb begin
      fwd_data  = 32'h0000_0000;
      can_fwd_s = 1'b0;
      case (wd_sel)
         WD_ALU: begin
            fwd_data  = alu_out;
            can_fwd_s = 1'b1;
         end
         WD_PC8: begin
            fwd_data  = pc_plus8(pc);
            can_fwd_s = 1'b1;
         end
         default: begin
            fwd_data  = 32'h0000_0000;
            can_fwd_s = 1'b0;
         end
      endcase
      fwd_ok = can_fwd_s && valid && (tnew == '0) && (wa != 5'd0);
   end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures E-stage results, ages Tnew by one stage
// and drives the M-stage forwarding bus.
module ex_mem_reg #(
   parameter logic [31:0] RESET_PC = ex_mem_reg_pkg::RESET_PC,
   parameter int          TNEW_W   = ex_mem_reg_pkg::TNEW_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              flush,
   input  logic [31:0]       e_pc,
   input  logic [31:0]       e_instr,
   input  logic [31:0]       e_alu_out,
   input  logic [31:0]       e_rt_data,
   input  logic [4:0]        e_wa,
   input  logic [1:0]        e_wd_sel,
   input  logic              e_mem_we,
   input  logic [TNEW_W-1:0] e_tnew,
   output logic [31:0]       m_pc,
   output logic [31:0]       m_instr,
   output logic [31:0]       m_alu_out,
   output logic [31:0]       m_rt_data,
   output logic [4:0]        m_wa,
   output logic [1:0]        m_wd_sel,
   output logic              m_mem_we,
   output logic [TNEW_W-1:0] m_tnew,
   output logic              m_valid,
   output logic [4:0]        fwd_addr,
   output logic [31:0]       fwd_data,
   output logic              fwd_ok
);
   import ex_mem_reg_pkg::*;

   logic [31:0]       pc_d, pc_q;
   logic [31:0]       instr_d, instr_q;
   logic [31:0]       alu_out_d, alu_out_q;
   logic [31:0]       rt_data_d, rt_data_q;
   logic [4:0]        wa_d, wa_q;
   logic [1:0]        wd_sel_d, wd_sel_q;
   logic              mem_we_d, mem_we_q;
   logic [TNEW_W-1:0] tnew_d, tnew_q;
   logic              valid_d, valid_q;
   logic [TNEW_W-1:0] tnew_aged_s;

   // Next state: flush beats stall beats load; a bubble keeps its PC.
   always_comb begin
      if (e_tnew == '0) begin
         tnew_aged_s = '0;
      end else begin
         tnew_aged_s = e_tnew - TNEW_W'(1);
      end

      pc_d      = pc_q;
      instr_d   = instr_q;
      alu_out_d = alu_out_q;
      rt_data_d = rt_data_q;
      wa_d      = wa_q;
      wd_sel_d  = wd_sel_q;
      mem_we_d  = mem_we_q;
      tnew_d    = tnew_q;
      valid_d   = valid_q;

      if (flush) begin
         pc_d      = e_pc;
         instr_d   = 32'h0000_0000;
         alu_out_d = 32'h0000_0000;
         rt_data_d = 32'h0000_0000;
         wa_d      = 5'd0;
         wd_sel_d  = WD_ALU;
         mem_we_d  = 1'b0;
         tnew_d    = '0;
         valid_d   = 1'b0;
      end else if (en) begin
         pc_d      = e_pc;
         instr_d   = e_instr;
         alu_out_d = e_alu_out;
         rt_data_d = e_rt_data;
         wa_d      = e_wa;
         wd_sel_d  = e_wd_sel;
         mem_we_d  = e_mem_we;
         tnew_d    = tnew_aged_s;
         valid_d   = 1'b1;
      end else begin
         valid_d   = valid_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         instr_q   <= 32'h0000_0000;
         alu_out_q <= 32'h0000_0000;
         rt_data_q <= 32'h0000_0000;
         wa_q      <= 5'd0;
         wd_sel_q  <= 2'd0;
         mem_we_q  <= 1'b0;
         tnew_q    <= '0;
         valid_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         alu_out_q <= alu_out_d;
         rt_data_q <= rt_data_d;
         wa_q      <= wa_d;
         wd_sel_q  <= wd_sel_d;
         mem_we_q  <= mem_we_d;
         tnew_q    <= tnew_d;
         valid_q   <= valid_d;
      end
   end

   assign m_pc      = pc_q;
   assign m_instr   = instr_q;
   assign m_alu_out = alu_out_q;
   assign m_rt_data = rt_data_q;
   assign m_wa      = wa_q;
   assign m_wd_sel  = wd_sel_q;
   assign m_mem_we  = mem_we_q;
   assign m_tnew    = tnew_q;
   assign m_valid   = valid_q;
   assign fwd_addr  = wa_q;

   ex_mem_reg_m_fwd_sel #(
      .TNEW_W (TNEW_W)
   ) u_m_fwd_sel (
      .wd_sel   (wd_sel_q),
      .wa       (wa_q),
      .tnew     (tnew_q),
      .valid    (valid_q),
      .alu_out  (alu_out_q),
      .pc       (pc_q),
      .fwd_data (fwd_data),
      .fwd_ok   (fwd_ok)
   );

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed self-checking bench for the EX/MEM pipeline register.
module tb_ex_mem_reg;
   import ex_mem_reg_pkg::*;

   logic        clk;
   logic        reset;
   logic        en;
   logic        flush;
   logic [31:0] e_pc, e_instr, e_alu_out, e_rt_data;
   logic [4:0]  e_wa;
   logic [1:0]  e_wd_sel;
   logic        e_mem_we;
   logic [1:0]  e_tnew;
   logic [31:0] m_pc, m_instr, m_alu_out, m_rt_data;
   logic [4:0]  m_wa;
   logic [1:0]  m_wd_sel;
   logic        m_mem_we;
   logic [1:0]  m_tnew;
   logic        m_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   logic        fwd_ok;

   int n_checks = 0;
   int n_fail   = 0;

   ex_mem_reg dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .e_pc(e_pc), .e_instr(e_instr), .e_alu_out(e_alu_out), .e_rt_data(e_rt_data),
      .e_wa(e_wa), .e_wd_sel(e_wd_sel), .e_mem_we(e_mem_we), .e_tnew(e_tnew),
      .m_pc(m_pc), .m_instr(m_instr), .m_alu_out(m_alu_out), .m_rt_data(m_rt_data),
      .m_wa(m_wa), .m_wd_sel(m_wd_sel), .m_mem_we(m_mem_we), .m_tnew(m_tnew),
      .m_valid(m_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_ok(fwd_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_e(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] alu, input logic [31:0] rt,
                        input logic [4:0] wa, input logic [1:0] wd_sel,
                        input logic we, input logic [1:0] tnew);
      e_pc = pc; e_instr = instr; e_alu_out = alu; e_rt_data = rt;
      e_wa = wa; e_wd_sel = wd_sel; e_mem_we = we; e_tnew = tnew;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; flush = 1'b0;
      set_e(32'h1111_1110, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 5'd7, 2'd2, 1'b1, 2'd3);
      #1;
      n_checks++; if (m_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc_async: got %h expected %h", m_pc, 32'h0000_3000); end
      tick(); tick();
      n_checks++; if (m_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", m_pc, 32'h0000_3000); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
      n_checks++; if (m_wa !== 5'd0 || m_instr !== 32'd0 || m_alu_out !== 32'd0 || m_rt_data !== 32'd0)
         begin n_fail++; $display("FAIL reset_fields: got wa=%0d instr=%h alu=%h rt=%h expected all 0", m_wa, m_instr, m_alu_out, m_rt_data); end
      n_checks++; if (m_wd_sel !== 2'd0 || m_mem_we !== 1'b0 || m_tnew !== 2'd0)
         begin n_fail++; $display("FAIL reset_ctrl: got wd_sel=%0d we=%b tnew=%0d expected 0 0 0", m_wd_sel, m_mem_we, m_tnew); end
      n_checks++; if (fwd_ok !== 1'b0 || fwd_data !== 32'd0)
         begin n_fail++; $display("FAIL reset_fwd: got ok=%b data=%h expected 0 0", fwd_ok, fwd_data); end
      reset = 1'b0;
   endtask

   task automatic test_alu_forward();
      set_e(32'h0000_3004, 32'h3508_1234, 32'h0000_1234, 32'h0000_0000, 5'd8, WD_ALU, 1'b0, 2'd1);
      tick();
      n_checks++; if (m_alu_out !== 32'h0000_1234) begin n_fail++; $display("FAIL ori_alu: got %h expected %h", m_alu_out, 32'h1234); end
      n_checks++; if (m_tnew !== 2'd0) begin n_fail++; $display("FAIL ori_tnew: got %0d expected 0", m_tnew); end
      n_checks++; if (fwd_addr !== 5'd8) begin n_fail++; $display("FAIL ori_fwd_addr: got %0d expected 8", fwd_addr); end
      n_checks++; if (fwd_data !== 32'h0000_1234) begin n_fail++; $display("FAIL ori_fwd_data: got %h expected %h", fwd_data, 32'h1234); end
      n_checks++; if (fwd_ok !== 1'b1) begin n_fail++; $display("FAIL ori_fwd_ok: got %b expected 1", fwd_ok); end
      n_checks++; if (m_valid !== 1'b1 || m_pc !== 32'h0000_3004 || m_instr !== 32'h3508_1234)
         begin n_fail++; $display("FAIL ori_fields: got valid=%b pc=%h instr=%h expected 1 00003004 35081234", m_valid, m_pc, m_instr); end
   endtask

   task automatic test_load_stall();
      set_e(32'h0000_3008, 32'h8C09_0000, 32'h0000_0010, 32'h0000_0055, 5'd9, WD_MEM, 1'b0, 2'd2);
      tick();
      n_checks++; if (m_tnew !== 2'd1) begin n_fail++; $display("FAIL lw_tnew: got %0d expected 1", m_tnew); end
      n_checks++; if (fwd_ok !== 1'b0 || fwd_data !== 32'd0) begin n_fail++; $display("FAIL lw_fwd: got ok=%b data=%h expected 0 0", fwd_ok, fwd_data); end
      en = 1'b0;
      set_e(32'h0000_300C, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 5'd12, WD_ALU, 1'b1, 2'd3);
      tick();
      n_checks++; if (m_tnew !== 2'd1) begin n_fail++; $display("FAIL stall_tnew: got %0d expected 1", m_tnew); end
      n_checks++; if (m_wa !== 5'd9 || m_pc !== 32'h0000_3008 || m_alu_out !== 32'h10 || m_rt_data !== 32'h55 || m_wd_sel !== WD_MEM || m_mem_we !== 1'b0 || m_valid !== 1'b1)
         begin n_fail++; $display("FAIL stall_hold: got wa=%0d pc=%h alu=%h rt=%h sel=%0d we=%b v=%b expected 9 00003008 10 55 1 0 1", m_wa, m_pc, m_alu_out, m_rt_data, m_wd_sel, m_mem_we, m_valid); end
      en = 1'b1;
   endtask

   task automatic test_jal_wrap();
      set_e(32'hFFFF_FFFC, 32'h0C00_0000, 32'h0000_0000, 32'h0000_0000, 5'd31, WD_PC8, 1'b0, 2'd0);
      tick();
      n_checks++; if (fwd_data !== 32'h0000_0004) begin n_fail++; $display("FAIL jal_fwd_data: got %h expected %h", fwd_data, 32'h4); end
      n_checks++; if (fwd_ok !== 1'b1 || fwd_addr !== 5'd31 || m_tnew !== 2'd0)
         begin n_fail++; $display("FAIL jal_fwd: got ok=%b addr=%0d tnew=%0d expected 1 31 0", fwd_ok, fwd_addr, m_tnew); end
   endtask

   task automatic test_flush_beats_stall();
      set_e(32'h0000_3014, 32'hAC0A_0004, 32'h0000_0104, 32'h0000_0077, 5'd10, WD_ALU, 1'b1, 2'd1);
      tick();
      n_checks++; if (m_mem_we !== 1'b1 || m_rt_data !== 32'h77) begin n_fail++; $display("FAIL sw_load: got we=%b rt=%h expected 1 77", m_mem_we, m_rt_data); end
      flush = 1'b1; en = 1'b0;
      set_e(32'h0000_3010, 32'h1234_5678, 32'h9999_9999, 32'h8888_8888, 5'd5, WD_ALU, 1'b1, 2'd1);
      tick();
      n_checks++; if (m_pc !== 32'h0000_3010) begin n_fail++; $display("FAIL flush_pc: got %h expected %h", m_pc, 32'h3010); end
      n_checks++; if (m_wa !== 5'd0 || m_mem_we !== 1'b0 || m_valid !== 1'b0 || fwd_ok !== 1'b0)
         begin n_fail++; $display("FAIL flush_ctrl: got wa=%0d we=%b valid=%b ok=%b expected 0 0 0 0", m_wa, m_mem_we, m_valid, fwd_ok); end
      n_checks++; if (m_instr !== 32'd0 || m_alu_out !== 32'd0 || m_rt_data !== 32'd0 || m_tnew !== 2'd0 || m_wd_sel !== 2'd0)
         begin n_fail++; $display("FAIL flush_data: got instr=%h alu=%h rt=%h tnew=%0d sel=%0d expected all 0", m_instr, m_alu_out, m_rt_data, m_tnew, m_wd_sel); end
      flush = 1'b0; en = 1'b1;
   endtask

   task automatic test_zero_reg();
      set_e(32'h0000_3018, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 5'd0, WD_ALU, 1'b0, 2'd0);
      tick();
      n_checks++; if (m_alu_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_alu: got %h expected %h", m_alu_out, 32'hDEADBEEF); end
      n_checks++; if (fwd_ok !== 1'b0) begin n_fail++; $display("FAIL zero_fwd_ok: got %b expected 0", fwd_ok); end
   endtask

   task automatic test_reserved_and_aging();
      set_e(32'h0000_301C, 32'h0000_0001, 32'h0000_5555, 32'h0000_0000, 5'd4, 2'd3, 1'b0, 2'd0);
      tick();
      n_checks++; if (m_wd_sel !== 2'd3 || fwd_ok !== 1'b0 || fwd_data !== 32'd0)
         begin n_fail++; $display("FAIL reserved_sel: got sel=%0d ok=%b data=%h expected 3 0 0", m_wd_sel, fwd_ok, fwd_data); end
      set_e(32'h0000_3020, 32'h0000_0002, 32'h0000_6666, 32'h0000_0000, 5'd6, WD_ALU, 1'b0, 2'd3);
      tick();
      n_checks++; if (m_tnew !== 2'd2 || fwd_ok !== 1'b0 || fwd_data !== 32'h6666)
         begin n_fail++; $display("FAIL age_tnew3: got tnew=%0d ok=%b data=%h expected 2 0 6666", m_tnew, fwd_ok, fwd_data); end
   endtask

   task automatic test_back_to_back();
      set_e(32'h0000_3024, 32'h0000_0003, 32'h0000_0A0A, 32'h0000_0000, 5'd2, WD_ALU, 1'b0, 2'd0);
      tick();
      set_e(32'h0000_3028, 32'h0000_0004, 32'h0000_0B0B, 32'h0000_0000, 5'd3, WD_PC8, 1'b0, 2'd0);
      #3;
      n_checks++; if (m_alu_out !== 32'h0A0A || m_pc !== 32'h3024 || fwd_addr !== 5'd2)
         begin n_fail++; $display("FAIL no_comb_path: got alu=%h pc=%h addr=%0d expected 0a0a 00003024 2", m_alu_out, m_pc, fwd_addr); end
      tick();
      n_checks++; if (m_alu_out !== 32'h0B0B || fwd_data !== 32'h0000_3030 || fwd_ok !== 1'b1)
         begin n_fail++; $display("FAIL b2b_second: got alu=%h data=%h ok=%b expected 0b0b 00003030 1", m_alu_out, fwd_data, fwd_ok); end
   endtask

   task automatic test_reset_while_busy();
      set_e(32'h0000_302C, 32'h0000_0005, 32'h0000_0C0C, 32'h0000_0011, 5'd13, WD_ALU, 1'b1, 2'd1);
      tick();
      flush = 1'b1; en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (m_pc !== 32'h0000_3000 || m_valid !== 1'b0 || fwd_ok !== 1'b0)
         begin n_fail++; $display("FAIL busy_reset_now: got pc=%h valid=%b ok=%b expected 00003000 0 0", m_pc, m_valid, fwd_ok); end
      n_checks++; if (m_wa !== 5'd0 || m_alu_out !== 32'd0 || m_rt_data !== 32'd0 || m_mem_we !== 1'b0 || m_instr !== 32'd0)
         begin n_fail++; $display("FAIL busy_reset_fields: got wa=%0d alu=%h rt=%h we=%b instr=%h expected all 0", m_wa, m_alu_out, m_rt_data, m_mem_we, m_instr); end
      tick();
      n_checks++; if (m_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL busy_reset_hold: got %h expected %h", m_pc, 32'h3000); end
      reset = 1'b0; flush = 1'b0; en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_alu_forward();
      test_load_stall();
      test_jal_wrap();
      test_flush_beats_stall();
      test_zero_reg();
      test_reserved_and_aging();
      test_back_to_back();
      test_reset_while_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
